// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: drives every input vector to a small gate, samples its output
// after SETTLE extra cycles and compares against an expected table. Option: TT_SWEEP_STOP_ON_ERR_EN.
module tt_sweep_ctrl #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt
);

  localparam logic [3:0]      CNT_INIT = 4'(SETTLE);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

`ifdef TT_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_IN-1:0]     r_vec;
  logic [3:0]          r_cnt;
  logic [N_IN-1:0]     r_dut_in;
  logic [2**N_IN-1:0]  r_tt;
  logic                r_pass;
  logic [N_IN:0]       r_err;

  logic                w_accept;
  logic                w_sample;
  logic                w_finish;
  logic                w_mis;
  logic [2**N_IN-1:0]  w_tt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_sample        = 1'b0;
    w_finish        = 1'b0;
    w_mis           = (dut_out != exp_tt[r_vec]);
    w_tt_nxt        = r_tt;
    w_tt_nxt[r_vec] = dut_out;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_sample = 1'b1;
          if ((r_vec == '1) || (STOP_ON_ERR && w_mis)) begin
            w_finish    = 1'b1;
            w_state_nxt = S_FIN;
          end
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // dut_in is kept as its own register so the gate sees a glitch-free, state-qualified vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_cnt    <= '0;
      r_dut_in <= '0;
      r_tt     <= '0;
      r_pass   <= 1'b0;
      r_err    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vec    <= '0;
            r_cnt    <= CNT_INIT;
            r_dut_in <= '0;
            r_tt     <= '0;
            r_pass   <= 1'b0;
            r_err    <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_pass   <= 1'b0;
            r_dut_in <= '0;
          end else if (!w_sample) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_tt <= w_tt_nxt;
            if (w_mis) r_err <= r_err + ERR_ONE;
            if (w_finish) begin
              r_pass   <= (w_tt_nxt == exp_tt);
              r_dut_in <= '0;
            end else begin
              r_vec    <= r_vec + VEC_ONE;
              r_cnt    <= CNT_INIT;
              r_dut_in <= r_vec + VEC_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_in  = r_dut_in;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_FIN);
  assign tt      = r_tt;
  assign pass    = r_pass;
  assign err_cnt = r_err;

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that exhaustively drives an N-input combinational gate through every input combination, samples its 1-bit output after a programmable settle time, and assembles the captured truth table. It compares the result against an expected table and reports pass/fail and a mismatch count. It sits between a host (start/abort handshake) and any small gate block in the combinational library, and provides on-chip self-check of those gates.

## Interface
- `N_IN`, default 3: number of gate inputs, legal range 1..4.
- `SETTLE`, default 1: extra cycles each vector is held before sampling, legal range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begins a sweep when idle. Level-sampled each edge.
- `abort` in 1: cancels the sweep in progress.
- `exp_tt` in 2**N_IN: expected table. Bit i is the expected output for vector i. Sampled at each sample edge.
- `dut_out` in 1: output of the gate under control.
- `dut_in` out N_IN: vector driven to the gate. Registered; bit N_IN-1 is the MSB input (x).
- `busy` out 1: high while a sweep runs.
- `done` out 1: one-cycle pulse when a sweep completes.
- `tt` out 2**N_IN: captured table. Bit i holds `dut_out` sampled for vector i.
- `pass` out 1: `tt == exp_tt` for the last completed sweep. Held until the next start.
- `err_cnt` out N_IN+1: number of mismatching vectors in the current or last sweep.

## Operation
- The FSM has three states: IDLE, RUN and FIN. Internal registers are `vec` (N_IN bits) and `cnt` (4 bits).
- **IDLE:**
  - `dut_in` = 0, `busy` = 0.
  - If `start` = 1 and `abort` = 0 at an edge: go to RUN, `vec`←0, `cnt`←SETTLE, `tt`←0, `err_cnt`←0, `pass`←0.
- **RUN:**
  - `busy` = 1 and `dut_in` = `vec`.
  - If `cnt` ≠ 0: decrement `cnt`.
  - If `cnt` = 0 (sample edge):
    - `tt[vec]`←`dut_out`.
    - If `dut_out` ≠ `exp_tt[vec]`, then `err_cnt`+1.
    - If `vec` = 2**N_IN−1: go to FIN and register `pass`.
    - Otherwise `vec`+1 and `cnt`←SETTLE.
- **FIN:**
  - `done` = 1 for exactly one cycle, `busy` = 0 and `dut_in` = 0.
  - Then unconditionally go to IDLE.
- `start` is ignored in RUN and FIN. No queuing.
- `abort` in RUN:
  - Next edge goes to IDLE with no `done`.
  - `pass`←0; `tt` and `err_cnt` keep their partial values.
- `abort` in IDLE wins over a simultaneous `start`: the sweep does not begin.
- `err_cnt` never wraps. Its width holds the maximum value 2**N_IN.
- `vec` increments only in RUN and never wraps within a sweep.
- Reset asserted mid-sweep immediately returns all state and outputs to reset values. No `done` is issued.

## Timing
- Reset values: state IDLE, `dut_in` 0, `busy` 0, `done` 0, `tt` 0, `pass` 0, `err_cnt` 0.
- Each vector is driven for SETTLE+1 cycles. The sample edge is the last edge of that window.
- Let E0 be the edge that accepts `start`. The last sample edge is E0 + 2**N_IN·(SETTLE+1).
  - `done` is high in the cycle following that edge.
  - `pass` is valid in that same cycle.
- `busy` rises in the cycle after E0 and falls when `done` rises.
- A new `start` is accepted at the edge ending the `done` cycle at the earliest: FIN→IDLE at that edge, then `start` at the next edge.

## Configuration
- `TT_SWEEP_STOP_ON_ERR_EN` defined:
  - At the first mismatching sample edge, go directly to FIN with `pass` = 0 and `err_cnt` = 1.
  - `tt` bits above the failing index remain 0.
- Not defined: the sweep always covers all 2**N_IN vectors and counts every mismatch.

## Test plan
1. **Reset.** Hold `rst_n` low mid-sweep. Required: all outputs are at reset values immediately; after release, IDLE with no `done`.
2. **Full pass.** N_IN=3, SETTLE=1, gate model `dut_out` = ~x, `exp_tt` = 8'h0F, pulse `start`. Required:
   - `dut_in` steps 0..7, 2 cycles each.
   - `done` is high one cycle, 16 edges after E0.
   - `tt` = 8'h0F, `pass` = 1, `err_cnt` = 0.
3. **Mismatch.** Same gate, `exp_tt` = 8'h0E.
   - Without the macro: `done` after 16 edges, `tt` = 8'h0F, `pass` = 0, `err_cnt` = 1.
   - With the macro: `done` after 2 edges, `tt` = 8'h01, `pass` = 0, `err_cnt` = 1.
4. **Abort.** Assert `abort` 5 cycles into a sweep. Required:
   - `busy` drops at the next edge, no `done`, `pass` = 0.
   - A subsequent `start` completes a normal sweep with `pass` = 1.
5. **Start/abort rules.**
   - `start` pulses while `busy` are ignored: exactly one `done` per accepted start.
   - `start` and `abort` together in IDLE: `busy` stays 0.
6. **Zero settle.** N_IN=2, SETTLE=0, `dut_out` = ~x, `exp_tt` = 4'h3. Required: `dut_in` 0,1,2,3 on consecutive cycles, `done` 4 edges after E0, `pass` = 1.
